data_ram_ctrl: RTL and testbench

//  Load/store front end for the byte-write data RAM. Accepts one core data request at a time.

---
 rtl/data_ram_pkg.sv | 29 ++
 rtl/load_align.sv | 24 ++
 rtl/data_ram_ctrl.sv | 103 ++++++++++
 tb/tb_data_ram_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM load/store front end.
package data_ram_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RSP
  } state_e;

  // Byte-enable pattern for an access of the given size at byte offset off.
  function automatic logic [3:0] be_mask(size_e size, logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a RAM read word and extends it to 32 bits.
module load_align
  import data_ram_pkg::*;
(
  input  logic [31:0] dout_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = dout_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Load/store front end for the byte-write data RAM: one outstanding request, checked for
// alignment and range, with a held valid/ready response.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = 4096,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_di,
  input  logic [31:0]           ram_dout
);

  state_e      state_q;
  size_e       size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [31:0] load_data;

  size_e       req_size_e;
  logic        range_err;
  logic        align_err;
  logic        req_err;
  logic        accept;

  assign req_size_e = size_e'(req_size);
  assign range_err  = |req_addr[31:ADDR_WIDTH+2];
  assign align_err  = (req_size_e == SZ_ILL) ||
                      (req_size_e == SZ_H && req_addr[0]) ||
                      (req_size_e == SZ_W && req_addr[1:0] != 2'b00);
  assign req_err    = range_err | align_err;

  // Gating with rstn keeps a store in its handshake cycle from reaching the RAM during reset.
  assign req_ready = rstn && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RSP);

  assign ram_addr = req_addr[ADDR_WIDTH+1:2];
  assign ram_we   = (accept && req_we && !req_err) ? be_mask(req_size_e, req_addr[1:0]) : 4'b0000;

  always_comb begin
    case (req_size_e)
      SZ_B:    ram_di = {4{req_wdata[7:0]}};
      SZ_H:    ram_di = {2{req_wdata[15:0]}};
      default: ram_di = req_wdata;
    endcase
  end

  load_align u_load_align (
    .dout_i     (ram_dout),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            size_q     <= req_size_e;
            unsigned_q <= req_unsigned;
            off_q      <= req_addr[1:0];
            rsp_rdata  <= '0;
            rsp_err    <= req_err;
            state_q    <= (req_we || req_err) ? RSP : RD;
          end
        end
        RD: begin
          rsp_rdata <= load_data;
          state_q   <= RSP;
        end
        RSP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl with an attached read-first byte-write RAM model.
module tb_data_ram_ctrl;

  localparam int unsigned MW = 4096;
  localparam int unsigned AW = $clog2(MW);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_di;
  logic [31:0]   ram_dout = '0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.MEM_SIZE_WORDS(MW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_dout     (ram_dout)
  );

  // Attached RAM: byte write enables, read-first, registered read data.
  logic [31:0] ram [MW] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
    ram_dout <= ram[ram_addr];
  end

  // Reference memory as a flat byte array.
  logic [7:0] mem_m [4*MW] = '{default: 8'h0};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  cur_we = 4'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected response and byte enables from the access rules, updating the reference memory.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output exp_t e, output logic [3:0] mask);
    int          n;
    logic        err;
    logic [31:0] v;
    logic [31:0] limit;
    n     = 1 << size;
    limit = 32'(4 * MW);
    err   = (size == 2'd3) || ((addr % 32'(n)) != 0) || (addr >= limit);
    e.err   = err;
    e.lat   = (we || err) ? 1 : 2;
    e.rdata = '0;
    mask    = 4'b0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[addr + 32'(i)] = wdata[8*i +: 8];
        mask = 4'(((1 << n) - 1) << addr[1:0]);
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[addr + 32'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        e.rdata = v;
      end
    end
  endtask

  // Monitor: checks RAM enables every cycle and compares responses against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      chk("ram_we", 32'(ram_we), (req_valid && req_ready) ? 32'(cur_we) : 32'd0);
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid) begin
        chk("req_ready_during_rsp", 32'(req_ready), 32'd0);
        if (sb_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sb_q[0];
          if (!prev_valid) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(sb_q.pop_front());
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    exp_t       e;
    logic [3:0] m;
    bit         hs;
    int         budget;
    model(we, addr, size, uns, wdata, e, m);
    sb_q.push_back(e);
    cur_we       = m;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    hs     = 1'b0;
    budget = 0;
    while (!hs && budget < 50) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    req_valid = 1'b0;
    cur_we    = 4'b0;
    if (!hs) begin
      fail_now("accept_timeout");
      sb_q.delete();
    end
  endtask

  task automatic wait_rsp(input bit rand_ready);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    rsp_ready = 1'b1;
    if (sb_q.size() != 0) begin
      fail_now("rsp_timeout");
      sb_q.delete();
    end
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata);
    issue(we, addr, size, uns, wdata);
    wait_rsp(1'b1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({name, "_ram_we"}, 32'(ram_we), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Word store/load round trip.
    run(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("t1_load_word", last_rdata, 32'hDEADBEEF);

    // Byte store into lane 3, signed/unsigned reload, neighbouring lanes preserved.
    run(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080);
    run(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    chk("t2_load_byte_s", last_rdata, 32'hFFFFFF80);
    run(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    chk("t2_load_byte_u", last_rdata, 32'h00000080);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("t2_load_word", last_rdata, 32'h80ADBEEF);

    // Half load, misaligned half store rejected.
    run(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
    chk("t3_load_half_s", last_rdata, 32'hFFFF80AD);
    run(1'b1, 32'h11, 2'd1, 1'b0, 32'h00001234);
    chk("t3_misaligned_err", 32'(last_err), 32'd1);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("t3_ram_unchanged", last_rdata, 32'h80ADBEEF);

    // Range and size errors; highest valid word still works.
    run(1'b0, 32'h4000, 2'd2, 1'b0, 32'h0);
    chk("t4_oor_err", 32'(last_err), 32'd1);
    chk("t4_oor_rdata", last_rdata, 32'd0);
    run(1'b1, 32'h4000, 2'd2, 1'b0, 32'hCAFEF00D);
    run(1'b0, 32'h20, 2'd3, 1'b0, 32'h0);
    chk("t4_size3_err", 32'(last_err), 32'd1);
    run(1'b1, 32'h3FFC, 2'd2, 1'b0, 32'h01234567);
    run(1'b0, 32'h3FFF, 2'd0, 1'b1, 32'h0);
    chk("t4_top_byte", last_rdata, 32'h00000001);

    // Response stall with a competing request that must be ignored.
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    rsp_ready    = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = 32'h20;
    req_size     = 2'd2;
    req_wdata    = 32'h55AA55AA;
    cur_we       = 4'hF;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk("t5_stalled_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    cur_we    = 4'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_idle_after_release", 32'(req_ready), 32'd1);
    chk("t5_rsp_consumed", 32'(sb_q.size()), 32'd0);
    run(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    chk("t5_ignored_store", last_rdata, 32'h0);

    // Reset while in RD discards the read.
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("t6_rd_reset");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("t6_after_rd_reset", last_rdata, 32'h80ADBEEF);

    // Reset during a store handshake cycle blocks the write.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_size  = 2'd2;
    req_wdata = 32'h12345678;
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("t6_wr_reset");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("t6_write_blocked", last_rdata, 32'h80ADBEEF);

    // Randomised traffic against the reference model.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h3FF0 + $urandom_range(0, 15);
        1:       a = 32'h4000 + $urandom_range(0, 7);
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 127));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    for (int w = 0; w < int'(MW); w++)
      chk("mem_final", ram[w], {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
